verify_load_sequencer: RTL and testbench
========================================

# verify_load_sequencer

Synthesizable host-side driver for the verify path of `combined_top`. It fetches a packed verify job (public key, signature and message) from a 64-bit word memory and streams it into the core's 64-bit valid/ready input in the order the core requires: rho, c, z, t1, mlen, m, h. It then collects the one-word accept/reject result and reports it. It replaces bench-driven loading in SoC integration and sits directly upstream of the core.

## Interface
Parameters:
- `AW`, 14: word address width of the job memory.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `go`  in  1  job start pulse; sampled only in IDLE.
- `sec_lvl`  in  3  security level, legal values 2, 3, 5; sampled with `go`.
- `base_addr`  in  AW  word address of rho word 0.
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  AW  read address.
- `mem_rdata`  in  64  read data, valid exactly 1 cycle after `mem_en`.
- `core_start`  out  1  one-cycle start pulse to core.
- `core_mode`  out  2  constant 1 (verify) while busy, 0 in IDLE.
- `core_sec_lvl`  out  3  latched `sec_lvl`.
- `core_valid_i`, `core_data_i[63:0]`  out  input stream to the core.
- `core_ready_i`  in  1  core accepts an input beat.
- `core_valid_o`, `core_data_o[63:0]`  in  result stream from the core.
- `core_ready_o`  out  1  sequencer accepts a result beat.
- `busy`  out  1  high from `go` acceptance until `done`.
- `done`  out  1  one-cycle pulse when the result has been captured.
- `reject`  out  1  valid with `done`: 1 iff `core_data_o == 1`.
- `err`  out  1  one-cycle pulse when `go` arrives with an illegal `sec_lvl`.

## Operation
- Memory layout is contiguous from `base_addr`: rho 4 words, c 4, z Z, t1 T, mlen 1 (bits [15:0] = byte length), m M, h H.
- Per-level section sizes (Z/T/H):
  - Level 2: 288/160/11.
  - Level 3: 400/240/8.
  - Level 5: 560/320/11.
- M = max(1, ceil(mlen/8)). For mlen = 0, one m word is still sent.
- States:
  - IDLE: `go` with legal level goes to START; illegal level pulses `err` and stays in IDLE.
  - START: assert `core_start` for 1 cycle, then go to STREAM.
  - STREAM: issue-side section/word counters drive `mem_addr`. Returned words enter a 2-entry FIFO whose head drives `core_valid_i`/`core_data_i`. A read is issued only when FIFO occupancy plus reads in flight is below 2. After the last h word pops, go to WAIT_RES.
  - WAIT_RES: `core_ready_o` = 1. On `core_valid_o`, latch `reject`, pulse `done`, and go to IDLE.
- mlen handling: after issuing the mlen read, the issue side stalls until that word returns. The returned mlen[15:0] is latched to compute M before the first m address is issued.
- The beat count for each section is exact. The sequencer never sends extra words and never skips a word under any `core_ready_i` pattern.
- `go` while busy is ignored.

## Timing
- Reset: all outputs 0, state IDLE, FIFO empty, in-flight reads discarded. Reset mid-job aborts without `done`.
- `go` at cycle 0 gives `core_start` = 1 at cycle 1, the first `mem_en` at cycle 1, and the first `core_valid_i` no later than cycle 3.
- With `core_ready_i` held at 1, throughput is 1 beat/cycle, with exactly one bubble after the mlen beat.
- Once `core_valid_i` is high, it and `core_data_i` stay stable until the beat is accepted (`core_valid_i & core_ready_i`).
- FIFO full with `core_ready_i` = 0: no new `mem_en` is issued. Simultaneous push and pop keeps occupancy unchanged.
- `done` is a pulse in the cycle after the result beat is accepted. `reject` holds its value until the next `go`.

## Structure
- Package `vy_seq_pkg`:
  - State enum.
  - Section enum (RHO, C, Z, T1, MLEN, M, H).
  - Per-level Z/T/H constants.
  - Function returning section length from level and mlen.
- Sub-module `vy_stream_fifo`: 2-entry, 64-bit, valid/ready, with occupancy output.

## Test plan
- Level 2, mlen = 33, `core_ready_i` = 1: 4+4+288+160+1+5+11 = 473 beats; `done` with `reject` = 0 when core data_o = 0.
- Level 3, mlen = 0: exactly 1 m word; h is 8 words; total 4+4+400+240+1+1+8 = 658 beats.
- Level 5 with random `core_ready_i` (50%): 4+4+560+320+1+M+11 beats, in order with no duplicates; data stays stable while stalled.
- `go` with `sec_lvl` = 4: `err` pulse, no `mem_en`, `busy` stays 0.
- `rst` = 0 asserted mid-z: all outputs 0 next cycle; a new `go` restarts from `base_addr` with a clean FIFO.
- Result beat `core_data_o` = 1: `reject` = 1 with `done`; a second `go` during the job is ignored.

Source files
------------

// File: rtl/vy_seq_pkg.sv
// Shared types, section sizes and length helper for the verify load sequencer.
package vy_seq_pkg;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 14;

    localparam int unsigned Z_L2 = 288;
    localparam int unsigned T_L2 = 160;
    localparam int unsigned H_L2 = 11;
    localparam int unsigned Z_L3 = 400;
    localparam int unsigned T_L3 = 240;
    localparam int unsigned H_L3 = 8;
    localparam int unsigned Z_L5 = 560;
    localparam int unsigned T_L5 = 320;
    localparam int unsigned H_L5 = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT_RES
    } state_t;

    typedef enum logic [2:0] {
        SEC_RHO,
        SEC_C,
        SEC_Z,
        SEC_T1,
        SEC_MLEN,
        SEC_M,
        SEC_H
    } sec_t;

    // Only levels 2, 3 and 5 have a defined job layout.
    function automatic logic lvl_legal(input logic [2:0] lvl);
        return (lvl == 3'd2) || (lvl == 3'd3) || (lvl == 3'd5);
    endfunction

    // Number of 64-bit words in a section; the message always occupies at least one word.
    function automatic logic [CW-1:0] sec_len(input logic [2:0] lvl, input sec_t sec,
                                              input logic [15:0] mlen);
        logic [16:0] m_words;
        m_words = (17'(mlen) + 17'd7) >> 3;
        sec_len = CW'(1);
        case (sec)
            SEC_RHO, SEC_C: sec_len = CW'(4);
            SEC_Z: begin
                case (lvl)
                    3'd2:    sec_len = CW'(Z_L2);
                    3'd3:    sec_len = CW'(Z_L3);
                    default: sec_len = CW'(Z_L5);
                endcase
            end
            SEC_T1: begin
                case (lvl)
                    3'd2:    sec_len = CW'(T_L2);
                    3'd3:    sec_len = CW'(T_L3);
                    default: sec_len = CW'(T_L5);
                endcase
            end
            SEC_MLEN: sec_len = CW'(1);
            SEC_M:    sec_len = (mlen == 16'd0) ? CW'(1) : CW'(m_words);
            SEC_H: begin
                case (lvl)
                    3'd2:    sec_len = CW'(H_L2);
                    3'd3:    sec_len = CW'(H_L3);
                    default: sec_len = CW'(H_L5);
                endcase
            end
            default: sec_len = CW'(1);
        endcase
    endfunction

endpackage

// File: rtl/vy_stream_fifo.sv
// Two-entry valid/ready word FIFO; the head register drives the output directly.
module vy_stream_fifo
    import vy_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [1:0]    cnt_q;
    logic          push;
    logic          pop;

    assign pop       = out_valid && out_ready;
    assign push      = in_valid && ((cnt_q != 2'd2) || pop);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign occ       = cnt_q;

    // Storage, pointers and occupancy; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/verify_load_sequencer.sv
// Fetches a packed verify job from word memory and streams it into the core, then captures the result.
module verify_load_sequencer
    import vy_seq_pkg::*;
#(
    parameter int unsigned AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [2:0]    sec_lvl,
    input  logic [AW-1:0] base_addr,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [63:0]   mem_rdata,
    output logic          core_start,
    output logic [1:0]    core_mode,
    output logic [2:0]    core_sec_lvl,
    output logic          core_valid_i,
    output logic [63:0]   core_data_i,
    input  logic          core_ready_i,
    input  logic          core_valid_o,
    input  logic [63:0]   core_data_o,
    output logic          core_ready_o,
    output logic          busy,
    output logic          done,
    output logic          reject,
    output logic          err
);

    state_t        state_q;
    sec_t          sec_q;
    logic [CW-1:0] word_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   mlen_q;
    logic          issue_done_q;
    logic          mlen_wait_q;
    logic          rd_pend_q;

    logic [1:0]    occ;
    logic [2:0]    committed;
    logic          pop;
    logic          issue_ok;
    logic          last_word;

    // Issue gate: words already committed (queued plus in flight, minus one leaving now) stay within two slots.
    assign pop       = core_valid_i && core_ready_i;
    assign committed = 3'(occ) + 3'(rd_pend_q);
    assign issue_ok  = ((state_q == ST_START) || (state_q == ST_STREAM)) && !issue_done_q
                       && !mlen_wait_q && (committed < (3'd2 + 3'(pop)));
    assign last_word = (word_q == (sec_len(core_sec_lvl, sec_q, mlen_q) - CW'(1)));
    assign mem_en    = issue_ok;
    assign mem_addr  = addr_q;

    vy_stream_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_pend_q),
        .in_data   (mem_rdata),
        .out_valid (core_valid_i),
        .out_data  (core_data_i),
        .out_ready (core_ready_i),
        .occ       (occ)
    );

    // Control FSM together with the issue-side section/word counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sec_q        <= SEC_RHO;
            word_q       <= '0;
            addr_q       <= '0;
            mlen_q       <= '0;
            issue_done_q <= 1'b0;
            mlen_wait_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
            core_start   <= 1'b0;
            core_mode    <= 2'd0;
            core_sec_lvl <= 3'd0;
            core_ready_o <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            reject       <= 1'b0;
            err          <= 1'b0;
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_pend_q  <= issue_ok;

            // The mlen word returns one cycle after its read; M depends on it.
            if (mlen_wait_q) begin
                mlen_q      <= mem_rdata[15:0];
                mlen_wait_q <= 1'b0;
            end

            if (issue_ok) begin
                addr_q <= addr_q + AW'(1);
                if (sec_q == SEC_MLEN) begin
                    mlen_wait_q <= 1'b1;
                end
                if (last_word) begin
                    word_q <= '0;
                    if (sec_q == SEC_H) begin
                        issue_done_q <= 1'b1;
                    end else begin
                        sec_q <= sec_t'(3'(sec_q) + 3'd1);
                    end
                end else begin
                    word_q <= word_q + CW'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        if (lvl_legal(sec_lvl)) begin
                            state_q      <= ST_START;
                            busy         <= 1'b1;
                            core_start   <= 1'b1;
                            core_mode    <= 2'd1;
                            core_sec_lvl <= sec_lvl;
                            addr_q       <= base_addr;
                            sec_q        <= SEC_RHO;
                            word_q       <= '0;
                            issue_done_q <= 1'b0;
                            reject       <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (issue_done_q && !rd_pend_q && (occ == {1'b0, pop})) begin
                        state_q      <= ST_WAIT_RES;
                        core_ready_o <= 1'b1;
                    end
                end
                ST_WAIT_RES: begin
                    if (core_valid_o && core_ready_o) begin
                        reject       <= (core_data_o == 64'd1);
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        core_mode    <= 2'd0;
                        core_ready_o <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verify_load_sequencer.sv
// Directed bench: job table plus hand sequences for illegal level, reset abort and ignored go.
module tb_verify_load_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [2:0]  sec_lvl;
    logic [13:0] base_addr;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        core_start;
    logic [1:0]  core_mode;
    logic [2:0]  core_sec_lvl;
    logic        core_valid_i;
    logic [63:0] core_data_i;
    logic        core_ready_i;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_ready_o;
    logic        busy;
    logic        done;
    logic        reject;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [0:16383];

    // Monitor state, owned by the main process.
    bit          mon_on = 1'b0;
    bit          rnd_ready = 1'b0;
    bit          stalled = 1'b0;
    logic [63:0] held;
    int          exp_base;
    int          exp_total;
    int          beat_idx;

    typedef struct {
        logic [2:0]  lvl;
        logic [15:0] mlen;
        int          mlen_off;
        int          base;
        bit          rnd;
        logic [63:0] res;
        int          total;
        bit          rej;
        bit          go_mid;
    } vec_t;

    vec_t vecs [5];

    verify_load_sequencer #(.AW(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .sec_lvl      (sec_lvl),
        .base_addr    (base_addr),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .core_start   (core_start),
        .core_mode    (core_mode),
        .core_sec_lvl (core_sec_lvl),
        .core_valid_i (core_valid_i),
        .core_data_i  (core_data_i),
        .core_ready_i (core_ready_i),
        .core_valid_o (core_valid_o),
        .core_data_o  (core_data_o),
        .core_ready_o (core_ready_o),
        .busy         (busy),
        .done         (done),
        .reject       (reject),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Job memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
        else        mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive ready after the edge, then check the stream at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        core_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (mon_on) begin
            if (stalled) begin
                chk("stall_valid", 64'(core_valid_i), 64'd1);
                chk("stall_data", core_data_i, held);
            end
            if (core_valid_i && core_ready_i) begin
                if (beat_idx >= exp_total) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got beat %0d expected only %0d", beat_idx, exp_total);
                end else begin
                    chk($sformatf("beat%0d", beat_idx), core_data_i, mem[exp_base + beat_idx]);
                end
                beat_idx++;
                stalled = 1'b0;
            end else if (core_valid_i) begin
                stalled = 1'b1;
                held    = core_data_i;
            end else begin
                stalled = 1'b0;
            end
        end
    endtask

    // Issue go at the falling edge and check the cycle-1 response.
    task automatic start_job(input logic [2:0] lvl, input int base, input logic [15:0] mlen,
                             input int mlen_off, input int total, input bit rnd);
        mem[base + mlen_off] = {48'hFACE_0000_0000, mlen};
        exp_base  = base;
        exp_total = total;
        beat_idx  = 0;
        stalled   = 1'b0;
        mon_on    = 1'b1;
        rnd_ready = rnd;
        sec_lvl   = lvl;
        base_addr = 14'(base);
        go        = 1'b1;
        tick();
        go = 1'b0;
        chk("c1_core_start", 64'(core_start), 64'd1);
        chk("c1_mem_en", 64'(mem_en), 64'd1);
        chk("c1_mem_addr", 64'(mem_addr), 64'(base));
        chk("c1_busy", 64'(busy), 64'd1);
        chk("c1_core_mode", 64'(core_mode), 64'd1);
        chk("c1_core_sec_lvl", 64'(core_sec_lvl), 64'(lvl));
    endtask

    task automatic run_job(input vec_t v);
        int c;
        int first_v;
        start_job(v.lvl, v.base, v.mlen, v.mlen_off, v.total, v.rnd);
        c       = 1;
        first_v = -1;
        while (!core_ready_o && c < 6000) begin
            if (first_v < 0 && core_valid_i) first_v = c;
            if (c == 2) chk("c2_core_start", 64'(core_start), 64'd0);
            if (v.go_mid && c == 20) begin
                go        = 1'b1;
                sec_lvl   = 3'd3;
                base_addr = 14'd0;
            end
            tick();
            c++;
            if (v.go_mid && c == 21) begin
                go        = 1'b0;
                sec_lvl   = v.lvl;
                base_addr = 14'(v.base);
                chk("midgo_core_start", 64'(core_start), 64'd0);
                chk("midgo_busy", 64'(busy), 64'd1);
                chk("midgo_sec_lvl", 64'(core_sec_lvl), 64'(v.lvl));
            end
        end
        if (!core_ready_o) begin
            chk("wait_res_timeout", 64'(c), 64'(v.total + 4));
            mon_on = 1'b0;
            return;
        end
        chk("first_valid_by_c3", 64'(first_v >= 0 && first_v <= 3), 64'd1);
        chk("beat_count", 64'(beat_idx), 64'(v.total));
        if (!v.rnd) chk("ready_o_cycle", 64'(c), 64'(v.total + 4));
        mon_on       = 1'b0;
        core_valid_o = 1'b1;
        core_data_o  = v.res;
        tick();
        core_valid_o = 1'b0;
        core_data_o  = 64'd0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("reject", 64'(reject), 64'(v.rej));
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("ready_o_after_done", 64'(core_ready_o), 64'd0);
        tick();
        chk("done_low", 64'(done), 64'd0);
        chk("reject_held", 64'(reject), 64'(v.rej));
        chk("mode_idle", 64'(core_mode), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_core_start"}, 64'(core_start), 64'd0);
        chk({tag, "_core_mode"}, 64'(core_mode), 64'd0);
        chk({tag, "_core_sec_lvl"}, 64'(core_sec_lvl), 64'd0);
        chk({tag, "_core_valid_i"}, 64'(core_valid_i), 64'd0);
        chk({tag, "_core_data_i"}, core_data_i, 64'd0);
        chk({tag, "_core_ready_o"}, 64'(core_ready_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_reject"}, 64'(reject), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        vec_t vr;
        logic [2:0] bad_lvls [2];

        // lvl, mlen, mlen offset (8+Z+T), base, random ready, result word, beats, reject, go mid-job
        vecs[0] = '{3'd2, 16'd33, 456, 100,   1'b0, 64'd0, 473, 1'b0, 1'b0};
        vecs[1] = '{3'd3, 16'd0,  648, 2000,  1'b0, 64'd0, 658, 1'b0, 1'b0};
        vecs[2] = '{3'd5, 16'd100, 888, 8000, 1'b1, 64'd1, 913, 1'b1, 1'b1};
        vecs[3] = '{3'd2, 16'd8,  456, 15900, 1'b1, 64'd2, 469, 1'b0, 1'b0};
        vecs[4] = '{3'd3, 16'd65, 648, 5000,  1'b0, 64'd1, 666, 1'b1, 1'b1};
        bad_lvls[0] = 3'd4;
        bad_lvls[1] = 3'd7;

        for (int a = 0; a < 16384; a++) mem[a] = {32'(a) ^ 32'hA5A5_0000, ~32'(a)};

        rst          = 1'b0;
        go           = 1'b0;
        sec_lvl      = 3'd0;
        base_addr    = 14'd0;
        core_valid_o = 1'b0;
        core_data_o  = 64'd0;
        core_ready_i = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Illegal levels: err pulse, nothing started.
        foreach (bad_lvls[i]) begin
            sec_lvl   = bad_lvls[i];
            base_addr = 14'd50;
            go        = 1'b1;
            tick();
            go = 1'b0;
            chk("illegal_err", 64'(err), 64'd1);
            chk("illegal_busy", 64'(busy), 64'd0);
            chk("illegal_mem_en", 64'(mem_en), 64'd0);
            chk("illegal_core_start", 64'(core_start), 64'd0);
            tick();
            chk("illegal_err_low", 64'(err), 64'd0);
            chk("illegal_busy_low", 64'(busy), 64'd0);
            chk("illegal_mem_en_low", 64'(mem_en), 64'd0);
        end

        // Reset in the middle of z, then a clean restart from the same base.
        start_job(3'd2, 3000, 16'd33, 456, 473, 1'b0);
        repeat (59) tick();
        chk("abort_in_z", 64'(beat_idx > 8 && beat_idx < 296), 64'd1);
        mon_on = 1'b0;
        rst    = 1'b0;
        tick();
        check_all_zero("abort");
        rst = 1'b1;
        tick();
        check_all_zero("abort_idle");
        vr = '{3'd2, 16'd33, 456, 3000, 1'b0, 64'd0, 473, 1'b0, 1'b0};
        run_job(vr);

        // Job table.
        for (int i = 0; i < 5; i++) run_job(vecs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
